// File: rtl/apb_mem_pkg.sv
// -----------------------------------------------------------------------------
// apb_mem_pkg
// Shared definitions for the apb_mem_ws APB3 slave memory:
//   - apb_state_t : transfer FSM state encoding (also exported on dbg_state)
//   - CNT_W       : width of the wait-state counter (wait counts 0..15)
//   - mem_words() : number of 32-bit words implemented for a byte size
// -----------------------------------------------------------------------------
package apb_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2
    } apb_state_t;

    localparam int CNT_W = 4;

    function automatic int mem_words(input int mem_bytes);
        return mem_bytes / 4;
    endfunction

endpackage

// File: rtl/apb_mem_ram.sv
// -----------------------------------------------------------------------------
// apb_mem_ram
// Single-port synchronous RAM with per-byte write enables and a registered,
// read-enabled output. Kept free of control logic so it maps onto block RAM.
// Ports:
//   clk   : clock, rising edge
//   addr  : word address
//   we    : per-byte write enables (bit i writes wdata[8i+7:8i])
//   wdata : write data
//   re    : read enable; rdata only changes on an edge with re=1
//   rdata : registered read data
// -----------------------------------------------------------------------------
module apb_mem_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic               clk,
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH/8-1:0] we,
    input  logic [WIDTH-1:0]   wdata,
    input  logic               re,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH / 8; i++) begin
            if (we[i]) begin
                mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/apb_mem_ws.sv
// -----------------------------------------------------------------------------
// apb_mem_ws
// APB3 slave memory with programmable read/write wait states and PSLVERR on
// out-of-range accesses. Intended to sit behind one slave port of an
// AXI-to-APB bridge.
//
// Optional build macro: APB_MEM_PSTRB_EN
//   defined   : PSTRB port exists; writes update only strobed byte lanes
//   undefined : no PSTRB port; every write updates all 4 bytes
//
// Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by
// access cycles (PSEL=1, PENABLE=1); it completes on the edge where
// PSEL & PENABLE & PREADY are all 1. PSLVERR and PRDATA are valid while
// PREADY=1. Dropping PSEL before completion abandons the transfer.
//
// Ports:
//   PCLK, PRESET          : clock (rising) and async active-high reset
//   PSEL, PENABLE, PWRITE : APB control
//   PADDR                 : byte address, only [ADDR_LENGTH-1:0] decoded
//   PWDATA, PSTRB         : write data and byte strobes (PSTRB optional)
//   PRDATA, PREADY, PSLVERR : response
//   dbg_state             : current FSM state
// -----------------------------------------------------------------------------
module apb_mem_ws
    import apb_mem_pkg::*;
#(
    parameter int WIDTH_PAD   = 32,
    parameter int WIDTH_PDA   = 32,
    parameter int WIDTH_PDS   = WIDTH_PDA / 8,
    parameter int ADDR_LENGTH = 12,
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_RD     = 0,
    parameter int WAIT_WR     = 0
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic                 PSEL,
    input  logic                 PENABLE,
    input  logic                 PWRITE,
    input  logic [WIDTH_PAD-1:0] PADDR,
    input  logic [WIDTH_PDA-1:0] PWDATA,
`ifdef APB_MEM_PSTRB_EN
    input  logic [WIDTH_PDS-1:0] PSTRB,
`endif
    output logic [WIDTH_PDA-1:0] PRDATA,
    output logic                 PREADY,
    output logic                 PSLVERR,
    output apb_state_t           dbg_state
);

    localparam int WORDS = mem_words(MEM_BYTES);
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [ADDR_LENGTH:0] MEM_LIMIT = (ADDR_LENGTH + 1)'(MEM_BYTES);
    localparam logic [CNT_W-1:0]     LOAD_RD   = CNT_W'(WAIT_RD);
    localparam logic [CNT_W-1:0]     LOAD_WR   = CNT_W'(WAIT_WR);

    apb_state_t           state;
    logic [CNT_W-1:0]     cnt;
    logic [AW-1:0]        idx_q;
    logic                 wr_q;
    logic                 oor_q;
    logic [WIDTH_PDA-1:0] wdata_q;
    logic [WIDTH_PDS-1:0] strb_q;
    // Forces PRDATA to zero after reset and after an error read; cleared by
    // an in-range read so the RAM's registered output is shown.
    logic                 rd_zero;

    logic                 setup;
    logic [ADDR_LENGTH:0] paddr_off;
    logic                 paddr_oor;
    logic [AW-1:0]        paddr_idx;
    logic [CNT_W-1:0]     cnt_load;
    logic [WIDTH_PDS-1:0] strb_in;

    logic [AW-1:0]        ram_addr;
    logic                 ram_re;
    logic [WIDTH_PDS-1:0] ram_we;
    logic [WIDTH_PDA-1:0] ram_rdata;

    // Only the decoded window and word index are used; the rest is ignored.
    logic unused_paddr;
    assign unused_paddr = ^PADDR;

`ifdef APB_MEM_PSTRB_EN
    assign strb_in = PSTRB;
`else
    assign strb_in = '1;
`endif

    assign setup     = PSEL && !PENABLE;
    assign paddr_off = {1'b0, PADDR[ADDR_LENGTH-1:0]};
    assign paddr_oor = (paddr_off >= MEM_LIMIT);
    // Out-of-range addresses alias onto real words here, so every RAM access
    // below is gated by the range flag.
    assign paddr_idx = PADDR[AW+1:2];
    assign cnt_load  = PWRITE ? LOAD_WR : LOAD_RD;

    assign PRDATA    = rd_zero ? '0 : ram_rdata;
    assign dbg_state = state;

    // RAM is addressed straight from PADDR in IDLE so a zero-wait read can
    // be captured on the setup edge; later it uses the latched index.
    always_comb begin
        ram_addr = (state == ST_IDLE) ? paddr_idx : idx_q;
        ram_re   = 1'b0;
        ram_we   = '0;
        case (state)
            ST_IDLE:  ram_re = setup && !PWRITE && !paddr_oor && (cnt_load == '0);
            ST_WAIT:  ram_re = PSEL && PENABLE && (cnt == CNT_W'(1)) && !wr_q && !oor_q;
            ST_READY: if (PSEL && PENABLE && wr_q && !oor_q) ram_we = strb_q;
            default:  ram_re = 1'b0;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            rd_zero <= 1'b1;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            oor_q   <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // PENABLE=1 without a setup phase is not a setup: ignored.
                    if (setup) begin
                        idx_q   <= paddr_idx;
                        wr_q    <= PWRITE;
                        wdata_q <= PWDATA;
                        strb_q  <= strb_in;
                        oor_q   <= paddr_oor;
                        cnt     <= cnt_load;
                        if (cnt_load == '0) begin
                            state   <= ST_READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= paddr_oor;
                            if (!PWRITE) rd_zero <= paddr_oor;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        state <= ST_IDLE;
                    end else if (PENABLE) begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state   <= ST_READY;
                            PREADY  <= 1'b1;
                            PSLVERR <= oor_q;
                            if (!wr_q) rd_zero <= oor_q;
                        end
                    end
                end
                ST_READY: begin
                    // Completion (write committed combinationally above) or abort.
                    if (!PSEL || PENABLE) begin
                        state   <= ST_IDLE;
                        PREADY  <= 1'b0;
                        PSLVERR <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    PREADY  <= 1'b0;
                    PSLVERR <= 1'b0;
                end
            endcase
        end
    end

    apb_mem_ram #(
        .WIDTH (WIDTH_PDA),
        .DEPTH (WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (PCLK),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (wdata_q),
        .re    (ram_re),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_apb_mem_ws.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_ws
// Three apb_mem_ws instances:
//   u0 : zero wait states, 4096 bytes
//   u1 : WAIT_RD=3, WAIT_WR=2, 4096 bytes
//   u2 : WAIT_RD=4, WAIT_WR=2, 2048 bytes (out-of-range, abort, reset tests)
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_apb_mem_ws;
    import apb_mem_pkg::*;

    logic        clk;
    logic        rst;
    logic        psel    [3];
    logic        penable [3];
    logic        pwrite  [3];
    logic [31:0] paddr   [3];
    logic [31:0] pwdata  [3];
    logic [3:0]  pstrb   [3];
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];
    apb_state_t  dbg     [3];

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    apb_mem_ws #(.WAIT_RD(0), .WAIT_WR(0), .MEM_BYTES(4096)) u0 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable[0]), .PWRITE(pwrite[0]),
        .PADDR(paddr[0]), .PWDATA(pwdata[0]),
`ifdef APB_MEM_PSTRB_EN
        .PSTRB(pstrb[0]),
`endif
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]), .dbg_state(dbg[0])
    );

    apb_mem_ws #(.WAIT_RD(3), .WAIT_WR(2), .MEM_BYTES(4096)) u1 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable[1]), .PWRITE(pwrite[1]),
        .PADDR(paddr[1]), .PWDATA(pwdata[1]),
`ifdef APB_MEM_PSTRB_EN
        .PSTRB(pstrb[1]),
`endif
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]), .dbg_state(dbg[1])
    );

    apb_mem_ws #(.WAIT_RD(4), .WAIT_WR(2), .MEM_BYTES(2048)) u2 (
        .PCLK(clk), .PRESET(rst), .PSEL(psel[2]), .PENABLE(penable[2]), .PWRITE(pwrite[2]),
        .PADDR(paddr[2]), .PWDATA(pwdata[2]),
`ifdef APB_MEM_PSTRB_EN
        .PSTRB(pstrb[2]),
`endif
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]), .dbg_state(dbg[2])
    );

    // ---------------- driver ----------------
    // Called 1 unit after a rising edge; returns 1 unit after the completion
    // edge with PSEL/PENABLE low, so a following call is back-to-back.
    task automatic apb_xfer(input int k, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] st,
                            output int waits, output logic [31:0] rd, output logic err);
        bit done;
        done  = 0;
        waits = 0;
        rd    = '0;
        err   = 1'b0;
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr;
        paddr[k] = addr; pwdata[k] = wd; pstrb[k] = st;
        @(posedge clk); #1;
        penable[k] = 1'b1;
        for (int c = 0; c < 40 && !done; c++) begin
            if (pready[k] === 1'b1) begin
                rd   = prdata[k];
                err  = pslverr[k];
                done = 1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        psel[k] = 1'b0; penable[k] = 1'b0;
        if (!done) begin
            total++; bad++;
            $display("FAIL xfer_timeout inst=%0d addr=%h: no PREADY in 40 cycles, required PREADY", k, addr);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            total++; if (pready[k] !== 1'b0)  begin bad++; $display("FAIL reset_pready inst=%0d got=%b exp=0", k, pready[k]); end
            total++; if (pslverr[k] !== 1'b0) begin bad++; $display("FAIL reset_pslverr inst=%0d got=%b exp=0", k, pslverr[k]); end
            total++; if (prdata[k] !== 32'h0) begin bad++; $display("FAIL reset_prdata inst=%0d got=%h exp=0", k, prdata[k]); end
            total++; if (dbg[k] !== ST_IDLE)  begin bad++; $display("FAIL reset_state inst=%0d got=%0d exp=0", k, dbg[k]); end
        end
    endtask

    task automatic test_zero_wait();
        int w; logic [31:0] rd, e; logic er;
        apb_xfer(0, 1'b1, 32'h010, 32'hDEAD_BEEF, 4'hF, w, rd, er);
        total++; if (w !== 0)     begin bad++; $display("FAIL zw_wr_waits got=%0d exp=0", w); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL zw_wr_err got=%b exp=0", er); end
        exp_q.push_back(32'hDEAD_BEEF);
        apb_xfer(0, 1'b0, 32'h010, 32'h0, 4'hF, w, rd, er);
        e = exp_q.pop_front();
        total++; if (rd !== e)    begin bad++; $display("FAIL zw_rd_data got=%h exp=%h", rd, e); end
        total++; if (w !== 0)     begin bad++; $display("FAIL zw_rd_waits got=%0d exp=0", w); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL zw_rd_err got=%b exp=0", er); end
        // PRDATA holds after the read and is not touched by a write.
        apb_xfer(0, 1'b1, 32'h014, 32'h0102_0304, 4'hF, w, rd, er);
        total++; if (prdata[0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL zw_prdata_hold got=%h exp=deadbeef", prdata[0]); end
    endtask

    task automatic test_back_to_back();
        int w; logic [31:0] rd, e; logic er;
        logic [31:0] data [8];
        for (int i = 0; i < 8; i++) begin
            data[i] = $urandom();
            apb_xfer(0, 1'b1, 32'h100 + 32'(4 * i) + 32'($urandom_range(0, 3)), data[i], 4'hF, w, rd, er);
        end
        for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(data[i]);
            apb_xfer(0, 1'b0, 32'h100 + 32'(4 * i) + 32'($urandom_range(0, 3)), 32'h0, 4'hF, w, rd, er);
            e = exp_q.pop_front();
            total++; if (rd !== e) begin bad++; $display("FAIL b2b_rd_data idx=%0d got=%h exp=%h", i, rd, e); end
        end
    endtask

    task automatic test_protocol_violation();
        int w; logic [31:0] rd, e; logic er;
        psel[0] = 1'b1; penable[0] = 1'b1; pwrite[0] = 1'b1; paddr[0] = 32'h010; pwdata[0] = 32'h0BAD_0BAD;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if (pready[0] !== 1'b0) begin bad++; $display("FAIL pv_pready cyc=%0d got=%b exp=0", c, pready[0]); end
            total++; if (dbg[0] !== ST_IDLE) begin bad++; $display("FAIL pv_state cyc=%0d got=%0d exp=0", c, dbg[0]); end
        end
        psel[0] = 1'b0; penable[0] = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(32'hDEAD_BEEF);
        apb_xfer(0, 1'b0, 32'h010, 32'h0, 4'hF, w, rd, er);
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL pv_rd_data got=%h exp=%h", rd, e); end
    endtask

    task automatic test_wait_states();
        int w; logic [31:0] rd, e; logic er;
        apb_xfer(1, 1'b1, 32'h0FFC, 32'h1234_5678, 4'hF, w, rd, er);
        total++; if (w !== 2)     begin bad++; $display("FAIL ws_wr_waits got=%0d exp=2", w); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL ws_wr_err got=%b exp=0", er); end
        apb_xfer(1, 1'b1, 32'h0000, 32'h8765_4321, 4'hF, w, rd, er);
        exp_q.push_back(32'h1234_5678);
        apb_xfer(1, 1'b0, 32'h0FFC, 32'h0, 4'hF, w, rd, er);
        e = exp_q.pop_front();
        total++; if (rd !== e)    begin bad++; $display("FAIL ws_rd_data got=%h exp=%h", rd, e); end
        total++; if (w !== 3)     begin bad++; $display("FAIL ws_rd_waits got=%0d exp=3", w); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL ws_rd_err got=%b exp=0", er); end
        exp_q.push_back(32'h8765_4321);
        apb_xfer(1, 1'b0, 32'h0000, 32'h0, 4'hF, w, rd, er);
        e = exp_q.pop_front();
        total++; if (rd !== e)    begin bad++; $display("FAIL ws_rd0_data got=%h exp=%h", rd, e); end
    endtask

    task automatic test_out_of_range();
        int w; logic [31:0] rd, e; logic er;
        apb_xfer(2, 1'b1, 32'h000, 32'hCAFE_F00D, 4'hF, w, rd, er);
        apb_xfer(2, 1'b1, 32'h7FC, 32'h7777_0001, 4'hF, w, rd, er);
        exp_q.push_back(32'h7777_0001);
        apb_xfer(2, 1'b0, 32'h7FC, 32'h0, 4'hF, w, rd, er);
        e = exp_q.pop_front();
        total++; if (rd !== e)    begin bad++; $display("FAIL oor_last_data got=%h exp=%h", rd, e); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL oor_last_err got=%b exp=0", er); end
        apb_xfer(2, 1'b1, 32'h800, 32'hA5A5_A5A5, 4'hF, w, rd, er);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_wr_err got=%b exp=1", er); end
        total++; if (w !== 2)     begin bad++; $display("FAIL oor_wr_waits got=%0d exp=2", w); end
        exp_q.push_back(32'h0);
        apb_xfer(2, 1'b0, 32'h800, 32'h0, 4'hF, w, rd, er);
        e = exp_q.pop_front();
        total++; if (rd !== e)    begin bad++; $display("FAIL oor_rd_data got=%h exp=%h", rd, e); end
        total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_rd_err got=%b exp=1", er); end
        total++; if (w !== 4)     begin bad++; $display("FAIL oor_rd_waits got=%0d exp=4", w); end
        apb_xfer(2, 1'b0, 32'hFFC, 32'h0, 4'hF, w, rd, er);
        total++; if (er !== 1'b1) begin bad++; $display("FAIL oor_top_err got=%b exp=1", er); end
        // Word 0 untouched by the rejected write; upper PADDR bits are not decoded.
        exp_q.push_back(32'hCAFE_F00D);
        apb_xfer(2, 1'b0, 32'h1000_0000, 32'h0, 4'hF, w, rd, er);
        e = exp_q.pop_front();
        total++; if (rd !== e)    begin bad++; $display("FAIL oor_word0_data got=%h exp=%h", rd, e); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL oor_word0_err got=%b exp=0", er); end
    endtask

`ifdef APB_MEM_PSTRB_EN
    task automatic test_pstrb();
        int w; logic [31:0] rd, e; logic er;
        apb_xfer(0, 1'b1, 32'h020, 32'hFFFF_FFFF, 4'hF, w, rd, er);
        apb_xfer(0, 1'b1, 32'h020, 32'h0000_0000, 4'b0101, w, rd, er);
        exp_q.push_back(32'hFF00_FF00);
        apb_xfer(0, 1'b0, 32'h020, 32'h0, 4'hF, w, rd, er);
        e = exp_q.pop_front();
        total++; if (rd !== e)    begin bad++; $display("FAIL strb_rd_data got=%h exp=%h", rd, e); end
        apb_xfer(0, 1'b1, 32'h020, 32'h1234_5678, 4'b0000, w, rd, er);
        total++; if (er !== 1'b0) begin bad++; $display("FAIL strb_zero_err got=%b exp=0", er); end
        exp_q.push_back(32'hFF00_FF00);
        apb_xfer(0, 1'b0, 32'h020, 32'h0, 4'hF, w, rd, er);
        e = exp_q.pop_front();
        total++; if (rd !== e)    begin bad++; $display("FAIL strb_zero_data got=%h exp=%h", rd, e); end
    endtask
`endif

    task automatic test_abort();
        int w; logic [31:0] rd, e; logic er;
        apb_xfer(2, 1'b1, 32'h010, 32'h1357_9BDF, 4'hF, w, rd, er);
        apb_xfer(2, 1'b0, 32'h000, 32'h0, 4'hF, w, rd, er);   // PRDATA now CAFEF00D
        // Abort a read after 2 access cycles.
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b0; paddr[2] = 32'h010;
        @(posedge clk); #1; penable[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1; psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk); #1;
        total++; if (dbg[2] !== ST_IDLE)          begin bad++; $display("FAIL abort_rd_state got=%0d exp=0", dbg[2]); end
        total++; if (pready[2] !== 1'b0)          begin bad++; $display("FAIL abort_rd_pready got=%b exp=0", pready[2]); end
        total++; if (prdata[2] !== 32'hCAFE_F00D) begin bad++; $display("FAIL abort_rd_prdata got=%h exp=cafef00d", prdata[2]); end
        // Abort a write while waiting.
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h010; pwdata[2] = 32'hFFFF_0000;
        @(posedge clk); #1; penable[2] = 1'b1;
        @(posedge clk); #1; psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk); #1;
        // Abort a write once PREADY is already high.
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h010; pwdata[2] = 32'h0000_FFFF;
        @(posedge clk); #1; penable[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (pready[2] !== 1'b1) begin bad++; $display("FAIL abort_wr_ready_pre got=%b exp=1", pready[2]); end
        psel[2] = 1'b0; penable[2] = 1'b0;
        @(posedge clk); #1;
        total++; if (pready[2] !== 1'b0) begin bad++; $display("FAIL abort_wr_pready got=%b exp=0", pready[2]); end
        exp_q.push_back(32'h1357_9BDF);
        apb_xfer(2, 1'b0, 32'h010, 32'h0, 4'hF, w, rd, er);
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL abort_fresh_data got=%h exp=%h", rd, e); end
        total++; if (w !== 4)  begin bad++; $display("FAIL abort_fresh_waits got=%0d exp=4", w); end
    endtask

    task automatic test_reset_mid();
        int w; logic [31:0] rd, e; logic er;
        apb_xfer(2, 1'b1, 32'h030, 32'h1111_2222, 4'hF, w, rd, er);
        apb_xfer(2, 1'b0, 32'h030, 32'h0, 4'hF, w, rd, er);
        // Reset during WAIT of a write.
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h030; pwdata[2] = 32'h9999_AAAA;
        @(posedge clk); #1; penable[2] = 1'b1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        total++; if (prdata[2] !== 32'h0) begin bad++; $display("FAIL rstmid_prdata got=%h exp=0", prdata[2]); end
        total++; if (pready[2] !== 1'b0)  begin bad++; $display("FAIL rstmid_pready got=%b exp=0", pready[2]); end
        total++; if (pslverr[2] !== 1'b0) begin bad++; $display("FAIL rstmid_pslverr got=%b exp=0", pslverr[2]); end
        total++; if (dbg[2] !== ST_IDLE)  begin bad++; $display("FAIL rstmid_state got=%0d exp=0", dbg[2]); end
        psel[2] = 1'b0; penable[2] = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        // Reset while an out-of-range write sits in READY.
        psel[2] = 1'b1; penable[2] = 1'b0; pwrite[2] = 1'b1; paddr[2] = 32'h830; pwdata[2] = 32'h5555_6666;
        @(posedge clk); #1; penable[2] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        total++; if (pready[2] !== 1'b0)  begin bad++; $display("FAIL rstrdy_pready got=%b exp=0", pready[2]); end
        total++; if (pslverr[2] !== 1'b0) begin bad++; $display("FAIL rstrdy_pslverr got=%b exp=0", pslverr[2]); end
        psel[2] = 1'b0; penable[2] = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(32'h1111_2222);
        apb_xfer(2, 1'b0, 32'h030, 32'h0, 4'hF, w, rd, er);
        e = exp_q.pop_front();
        total++; if (rd !== e) begin bad++; $display("FAIL rstmid_rd_data got=%h exp=%h", rd, e); end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = '0; pwdata[k] = '0; pstrb[k] = 4'hF;
        end
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        #3 rst = 1'b0;
        @(posedge clk); #1;
        test_zero_wait();
        test_back_to_back();
        test_protocol_violation();
        test_wait_states();
        test_out_of_range();
`ifdef APB_MEM_PSTRB_EN
        test_pstrb();
`endif
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
